// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_IGNORE
    } i2c_rx_state_t;

    localparam int         I2C_ADDR_W        = 7;
    localparam logic [6:0] I2C_GEN_CALL_ADDR = 7'h00;
    localparam logic       I2C_RW_WRITE      = 1'b0;

endpackage

// File: rtl/i2c_rx_fifo.sv
// Small synchronous FIFO buffering received bytes toward the system-side consumer.
module i2c_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; the head is forced to zero while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: START/STOP detection, 7-bit address match, ACKed bursts into a FIFO.
// Optional general-call acceptance is enabled by defining I2C_RX_GENERAL_CALL_EN.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_BYTES   = 16,
    parameter int CNT_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    output logic [7:0]            data_o,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  start_o,
    output logic                  stop_o,
    output logic                  busy,
    output logic                  overrun,
    output logic [CNT_W-1:0]      byte_count,
    output logic                  gen_call
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_q;
    logic                   r_sda_q;

    i2c_rx_state_t          r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_ack_pending;
    logic                   r_ack_drv;
    logic                   r_sda_oe;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_overrun;
    logic                   r_busy;
    logic                   r_gen_call;
    logic [CNT_W-1:0]       r_byte_count;

    logic w_scl_s, w_sda_s;
    logic w_start, w_stop, w_scl_rise, w_scl_fall;
    logic w_last_bit, w_room, w_push, w_addr_match, w_gc_match;
    logic w_fifo_full, w_fifo_empty;
    logic [7:0] w_byte;

    // NOTE: non-blocking assignments so each stage captures its neighbour's previous value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_q    <= 1'b1;
            r_sda_q    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_q    <= w_scl_s;
            r_sda_q    <= w_sda_s;
        end
    end

    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_start    = w_scl_s & r_sda_q & ~w_sda_s;
    assign w_stop     = w_scl_s & ~r_sda_q & w_sda_s;
    assign w_scl_rise = w_scl_s & ~r_scl_q;
    assign w_scl_fall = ~w_scl_s & r_scl_q;

    assign w_byte       = {r_shift, w_sda_s};
    assign w_last_bit   = w_scl_rise && (r_bit_cnt == 3'd0);
    assign w_room       = ~w_fifo_full && (r_byte_count < CNT_W'(MAX_BYTES));
    assign w_push       = (r_state == ST_DATA) && w_last_bit && w_room && !w_start && !w_stop;
    assign w_addr_match = (w_byte[7:1] == own_addr) && (w_byte[0] == I2C_RW_WRITE);
`ifdef I2C_RX_GENERAL_CALL_EN
    assign w_gc_match   = (w_byte == {I2C_GEN_CALL_ADDR, I2C_RW_WRITE});
`else
    assign w_gc_match   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd7;
            r_shift       <= '0;
            r_ack_pending <= 1'b0;
            r_ack_drv     <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_start       <= 1'b0;
            r_stop        <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
            r_gen_call    <= 1'b0;
            r_byte_count  <= '0;
        end else begin
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_overrun <= 1'b0;
            if (w_start) begin
                r_state      <= ST_ADDR;
                r_bit_cnt    <= 3'd7;
                r_byte_count <= '0;
                r_gen_call   <= 1'b0;
                r_busy       <= 1'b1;
                r_start      <= 1'b1;
                r_sda_oe     <= 1'b0;
                r_ack_drv    <= 1'b0;
            end else if (w_stop) begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_sda_oe   <= 1'b0;
                r_stop     <= 1'b1;
                r_gen_call <= 1'b0;
                r_ack_drv  <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                        end
                        if (w_last_bit && r_state == ST_ADDR) begin
                            r_ack_pending <= w_addr_match | w_gc_match;
                            r_gen_call    <= w_gc_match;
                            r_state       <= ST_ADDR_ACK;
                        end else if (w_last_bit) begin
                            // A rejected byte is NACKed and the rest of the frame ignored.
                            r_ack_pending <= w_room;
                            r_overrun     <= ~w_room;
                            if (w_room) r_byte_count <= r_byte_count + CNT_W'(1);
                            r_state       <= ST_DATA_ACK;
                        end
                    end
                    ST_ADDR_ACK, ST_DATA_ACK: begin
                        if (w_scl_fall && !r_ack_drv) begin
                            r_ack_drv <= 1'b1;
                            r_sda_oe  <= r_ack_pending;
                        end else if (w_scl_fall) begin
                            r_ack_drv <= 1'b0;
                            r_sda_oe  <= 1'b0;
                            r_state   <= r_ack_pending ? ST_DATA : ST_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    i2c_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_push),
        .i_push_data (w_byte),
        .i_pop       (data_ready),
        .o_head      (data_o),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign data_valid = ~w_fifo_empty;
    assign sda_oe     = r_sda_oe;
    assign start_o    = r_start;
    assign stop_o     = r_stop;
    assign overrun    = r_overrun;
    assign busy       = r_busy;
    assign byte_count = r_byte_count;
    assign gen_call   = r_gen_call;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bus-level master tasks, transaction-level model, directed and random frames.
module tb_i2c_target_rx;

    localparam int DEPTH = 4;
    localparam int MAXB  = 16;
    localparam int CNT_W = $clog2(MAXB + 1);
`ifdef I2C_RX_GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             scl_m = 1'b1;
    logic             sda_m = 1'b1;
    logic             sda_line;
    logic             sda_oe;
    logic [6:0]       own_addr = 7'h42;
    logic [7:0]       data_o;
    logic             data_valid;
    logic             data_ready = 1'b0;
    logic             start_o, stop_o, busy, overrun, gen_call;
    logic [CNT_W-1:0] byte_count;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_rx #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (DEPTH),
        .MAX_BYTES   (MAXB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .scl_i      (scl_m),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .own_addr   (own_addr),
        .data_o     (data_o),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy       (busy),
        .overrun    (overrun),
        .byte_count (byte_count),
        .gen_call   (gen_call)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         n_start = 0, n_stop = 0, n_ovr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pop_log[$];
    logic [7:0] txn_data[$];
    bit         ack_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: pulse counting and FIFO delivery against the expected-byte queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (start_o) n_start++;
            if (stop_o)  n_stop++;
            if (overrun) n_ovr++;
            if (data_valid) begin
                check("valid_with_pending_byte", 32'(exp_q.size() != 0), 1);
                if (data_ready && exp_q.size() != 0) begin
                    check("pop_data", data_o, exp_q[0]);
                    pop_log.push_back(data_o);
                    exp_q.delete(0);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(3);
        scl_m = 1'b1;
        tick(3);
        check("oe_idle_in_data_bit", sda_oe, 0);
        tick(3);
        scl_m = 1'b0;
        tick(3);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        tick(3);
        scl_m = 1'b1;
        tick(3);
        acked = sda_oe;
        tick(3);
        scl_m = 1'b0;
        tick(3);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        tick(3);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b0;
        tick(6);
        scl_m = 1'b0;
        tick(3);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        tick(3);
        scl_m = 1'b1;
        tick(6);
        sda_m = 1'b1;
        tick(6);
    endtask

    task automatic drain();
        data_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        check("drain_pending", exp_q.size(), 0);
        tick(2);
        check("empty_after_drain", data_valid, 0);
    endtask

    // Transaction-level model: acceptance decided from queue occupancy and the byte budget.
    task automatic run_txn(input logic [7:0] addr, input bit rdy);
        int  st0, sp0, ov0, cnt, novr;
        bit  exp_ack, ignoring, accept, ack;
        st0 = n_start; sp0 = n_stop; ov0 = n_ovr;
        cnt = 0; novr = 0;
        ack_log.delete();
        data_ready = rdy;
        start_cond();
        check("busy_after_start", busy, 1);
        check("count_after_start", byte_count, 0);
        exp_ack = ((addr[7:1] == own_addr) && !addr[0]) || (GC_EN && addr == 8'h00);
        send_byte(addr, ack);
        ack_log.push_back(ack);
        check("addr_ack", ack, exp_ack);
        check("gen_call_flag", gen_call, GC_EN && addr == 8'h00);
        ignoring = !exp_ack;
        foreach (txn_data[i]) begin
            accept = !ignoring && exp_q.size() < DEPTH && cnt < MAXB;
            if (!ignoring && !accept) begin
                novr++;
                ignoring = 1'b1;
            end
            if (accept) begin
                exp_q.push_back(txn_data[i]);
                cnt++;
            end
            send_byte(txn_data[i], ack);
            ack_log.push_back(ack);
            check("data_ack", ack, accept);
        end
        check("byte_count", byte_count, cnt);
        check("busy_before_stop", busy, 1);
        stop_cond();
        check("busy_after_stop", busy, 0);
        check("gen_call_after_stop", gen_call, 0);
        check("start_pulses", n_start - st0, 1);
        check("stop_pulses", n_stop - sp0, 1);
        check("overrun_pulses", n_ovr - ov0, novr);
        drain();
        data_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ack;
        int s0;
        tick(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_data_o", data_o, 0);
        check("rst_busy", busy, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_gen_call", gen_call, 0);
        check("rst_pulses", {start_o, stop_o, overrun}, 0);
        rstn = 1'b1;
        tick(4);

        // Basic write burst with consumer always ready.
        pop_log.delete();
        txn_data = '{8'hA5, 8'h3C};
        run_txn(8'h84, 1'b1);
        check("t1_ack_count", ack_log.size(), 3);
        check("t1_acks", {ack_log[0], ack_log[1], ack_log[2]}, 3'b111);
        check("t1_pop_count", pop_log.size(), 2);
        check("t1_pop0", pop_log[0], 8'hA5);
        check("t1_pop1", pop_log[1], 8'h3C);

        // Foreign address: no drive, nothing delivered.
        pop_log.delete();
        txn_data = '{8'h11, 8'h22};
        run_txn(8'h86, 1'b1);
        check("t2_acks", {ack_log[0], ack_log[1], ack_log[2]}, 3'b000);
        check("t2_pops", pop_log.size(), 0);

        // Read to own address: NACK, rest ignored.
        pop_log.delete();
        txn_data = '{8'h55, 8'h66};
        run_txn(8'h85, 1'b1);
        check("t3_acks", {ack_log[0], ack_log[1], ack_log[2]}, 3'b000);
        check("t3_pops", pop_log.size(), 0);

        // FIFO fill with consumer stalled: fifth byte overflows.
        pop_log.delete();
        s0 = n_ovr;
        txn_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_txn(8'h84, 1'b0);
        check("t4_acks", {ack_log[0], ack_log[1], ack_log[2], ack_log[3], ack_log[4], ack_log[5]}, 6'b111110);
        check("t4_overrun", n_ovr - s0, 1);
        check("t4_pop_count", pop_log.size(), 4);
        check("t4_pops", {pop_log[0], pop_log[1], pop_log[2], pop_log[3]}, 32'h01020304);

        // Repeated START in the middle of a data byte.
        pop_log.delete();
        s0 = n_start;
        data_ready = 1'b1;
        start_cond();
        send_byte(8'h84, ack);
        check("t5_addr_ack", ack, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        start_cond();
        check("t5_count_restart", byte_count, 0);
        send_byte(8'h84, ack);
        check("t5_addr2_ack", ack, 1);
        exp_q.push_back(8'h77);
        send_byte(8'h77, ack);
        check("t5_data_ack", ack, 1);
        check("t5_byte_count", byte_count, 1);
        stop_cond();
        drain();
        check("t5_starts", n_start - s0, 2);
        check("t5_pop_count", pop_log.size(), 1);
        check("t5_pop0", pop_log[0], 8'h77);
        data_ready = 1'b0;

        // Reset asserted while SDA is being pulled for an ACK.
        start_cond();
        send_byte(8'h84, ack);
        exp_q.push_back(8'h11);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h11 >> i));
        sda_m = 1'b1;
        tick(2);
        check("t6_oe_in_ack", sda_oe, 1);
        check("t6_valid_before_rst", data_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_oe_async_clear", sda_oe, 0);
        check("t6_valid_cleared", data_valid, 0);
        check("t6_busy_cleared", busy, 0);
        check("t6_count_cleared", byte_count, 0);
        exp_q.delete();
        tick(2);
        rstn = 1'b1;
        tick(2);
        scl_m = 1'b1;
        tick(6);

        // General call address.
        pop_log.delete();
        txn_data = '{8'h06};
        run_txn(8'h00, 1'b1);
        check("t7_acks", {ack_log[0], ack_log[1]}, GC_EN ? 2'b11 : 2'b00);
        check("t7_pop_count", pop_log.size(), GC_EN ? 1 : 0);

        // Randomised frames against the model.
        for (int t = 0; t < 20; t++) begin
            int sel, n;
            logic [7:0] addr;
            sel = $urandom_range(0, 99);
            if (sel < 50)      addr = {own_addr, 1'b0};
            else if (sel < 62) addr = {own_addr, 1'b1};
            else if (sel < 70) addr = 8'h00;
            else               addr = 8'($urandom_range(0, 255));
            n = $urandom_range(0, 18);
            txn_data.delete();
            for (int k = 0; k < n; k++) txn_data.push_back(8'($urandom_range(0, 255)));
            run_txn(addr, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
Parametrised successor to the single-byte I2C receiver: a write-only I2C target receiver. It synchronises raw SCL/SDA, detects START, repeated START and STOP, and matches a 7-bit own address. It receives multi-byte write bursts with ACK/NACK generation and buffers the bytes in a small FIFO with a valid/ready interface toward the register/bus-bridge logic. It sits between the pad-level i2c lines and the system-side consumer.

Parameters:
SYNC_STAGES, 2, flops in the SCL/SDA input synchronisers (min 2)
FIFO_DEPTH, 4, receive FIFO entries (power of two, ≥2)
MAX_BYTES, 16, data bytes ACKed per transaction; byte MAX_BYTES+1 onward NACKed
CNT_W, $clog2(MAX_BYTES+1), width of byte_count

Ports:
clk  in  1  system clock, ≥10× SCL rate
rstn  in  1  asynchronous active-low reset
scl_i  in  1  raw SCL pad input
sda_i  in  1  raw SDA pad input
sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
own_addr  in  7  target address; static while busy=0→1
data_o  out  8  FIFO head byte
data_valid  out  1  FIFO non-empty
data_ready  in  1  consumer pop; pop occurs when data_valid & data_ready
start_o  out  1  1-cycle pulse on START/repeated START
stop_o  out  1  1-cycle pulse on STOP
busy  out  1  1 from START until STOP
overrun  out  1  1-cycle pulse when a data byte is NACKed for FIFO full or MAX_BYTES
byte_count  out  CNT_W  bytes accepted in current transaction, saturates at MAX_BYTES
gen_call  out  1  transaction addressed to general call (see Optional Feature)

Behaviour:
- Reset (rstn=0, async): sda_oe=0, data_valid=0, data_o=0, start_o=stop_o=overrun=0, busy=0, byte_count=0, gen_call=0, FIFO empty, state IDLE. Reset mid-transfer drops the partial byte and releases SDA immediately.
- Synchronisers reset to 1. All edge detection uses the synchronised scl_s/sda_s and their previous-cycle values.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1. Both are honoured in every state and take priority over bit sampling in the same cycle.
- START → state ADDR, bit counter=7, byte_count=0, gen_call=0, busy=1, start_o pulse. STOP → IDLE, busy=0, sda_oe=0, stop_o pulse.
- Bits sampled MSB first on the synchronised SCL rising edge.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- ADDR: after 8 bits, compare addr[7:1] with own_addr and check R/W=addr[0].
  - Match with W (0): ack_pending=1, next DATA.
  - Match with R (1): NACK, next IGNORE.
  - Mismatch: no drive, next IGNORE.
- ADDR_ACK / DATA_ACK: on the SCL falling edge following the 8th bit, sda_oe is set if ack_pending. sda_oe is cleared on the next SCL falling edge, then the FSM moves to the next state.
- DATA: after the 8th rising edge, the byte is accepted iff FIFO not full and byte_count<MAX_BYTES.
  - Accepted: push to FIFO the same cycle, byte_count+1, ACK.
  - Rejected: byte dropped, overrun pulse, NACK, then IGNORE.
- IGNORE: never drives SDA; waits for START or STOP.
- Latency: data_valid rises 1 clk after the synchronised 8th SCL rising edge when FIFO was empty.
- FIFO: full is evaluated on pre-pop occupancy. Push and pop in the same cycle when full: the push is still rejected (conservative). When empty, data_ready is ignored. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
I2C_RX_GENERAL_CALL_EN
- Defined: address byte 0x00 (W) is treated as a match (ACK, DATA state) and gen_call=1 until the next START/STOP. Address 0x01 is NACKed → IGNORE.
- Undefined: 0x00 follows normal compare (own_addr=0 illegal), and gen_call is tied 0.

Decomposition:
- Package i2c_pkg: state enum i2c_rx_state_t, I2C_ADDR_W=7, I2C_GEN_CALL_ADDR=7'h00, I2C_RW_WRITE=1'b0.
- Sub-module i2c_rx_fifo (params WIDTH=8, DEPTH): synchronous FIFO with push/pop/full/empty on clk/rstn.
- Synchroniser and edge detection stay inline.

Test Plan:
- own_addr=7'h42; START, 0x84, 0xA5, 0x3C, STOP; data_ready=1 → two ACKs after address, FIFO pops A5 then 3C, byte_count=2, start_o/stop_o pulse once each.
- own_addr=7'h42; address 0x86 → no sda_oe assertion for the whole frame, no pushes, busy=1 until STOP.
- Address 0x85 (read to own) → NACK, IGNORE; following bytes not pushed, sda_oe stays 0.
- FIFO_DEPTH=4, data_ready=0, 5 data bytes 0x01..0x05 → bytes 1–4 ACKed, byte 5 NACKed, overrun pulse; pops yield 01,02,03,04.
- Repeated START mid-byte then address 0x84, byte 0x77 → partial byte discarded, byte_count restarts at 1, 0x77 delivered.
- rstn low during ACK slot → sda_oe=0 asynchronously, data_valid=0; with I2C_RX_GENERAL_CALL_EN, address 0x00 + byte 0x06 → ACK, gen_call=1, 0x06 delivered.
